// File: rtl/prog_timer_pkg.sv
// Shared types and defaults for the programmable down-timer.
package prog_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 4;

endpackage

// File: rtl/prog_down_timer_if.sv
// Load-value valid/ready channel into the down-timer.
interface prog_down_timer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;

  modport master (output load_valid, output load_value, input  load_ready);
  modport slave  (input  load_valid, input  load_value, output load_ready);
endinterface

// File: rtl/prog_down_timer_tick_prescaler.sv
// Clock divider: one tick every (prescale+1) enabled cycles; holds its phase while disabled.
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  assign tick = en & (pcnt_q == prescale);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/prog_down_timer.sv
// Loadable down-counter with prescaled tick, one-cycle expiry pulse and optional auto-reload.
module prog_down_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  prog_down_timer_if.slave      ld,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  auto_reload,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expired
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;
  logic             tick;

  // Prescaler only runs in RUN; outside RUN it is held at phase zero.
  tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q != RUN),
    .en       ((state_q == RUN) & ~pause),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld.load_valid) begin
          reload_d = ld.load_value;
          count_d  = ld.load_value;
          state_d  = LOADED;
        end
      end
      LOADED: begin
        if (ld.load_valid) begin
          reload_d = ld.load_value;
          count_d  = ld.load_value;
        end else if (start) begin
          if (count_q != '0) begin
            state_d = RUN;
          end else begin
            state_d   = DONE;
            expired_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (tick) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            expired_d = (count_q == WIDTH'(1));
            if (auto_reload && (reload_q != '0) && (count_q == WIDTH'(1))) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (ld.load_valid) begin
          reload_d = ld.load_value;
          count_d  = ld.load_value;
          state_d  = LOADED;
        end else if (start) begin
          count_d = reload_q;
          if (reload_q != '0) state_d = RUN;
          else                expired_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  assign ld.load_ready = (state_q != RUN);
  assign count         = count_q;
  assign busy          = (state_q == RUN);
  assign expired       = expired_q;

endmodule
